// File: rtl/ysyx_23060111_ifu_axil_if.sv
// Simplified AXI-lite read channel (AR/R) between the fetch unit and instruction memory.
interface ysyx_23060111_ifu_axil_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060111_ifu_axil.sv
// Multi-cycle, non-overlapped instruction fetch unit: one AXI-lite read per instruction,
// hands the word to decode, then waits for execute to return the next PC.
module ysyx_23060111_ifu_axil #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_23060111_ifu_axil_if.master         bus,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_inst,
  output logic [31:0]                      out_pc,
  input  logic                             npc_valid,
  input  logic [31:0]                      npc,
  output logic                             fault,
  output logic [31:0]                      fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    OUT  = 3'd3,
    WAIT = 3'd4,
    HALT = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      inst  <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: state <= AR;
        AR:   if (bus.arready) state <= R;
        R: begin
          // The word is captured even on an error response so it can be inspected after the halt.
          if (bus.rvalid) begin
            inst  <= bus.rdata;
            state <= (bus.rresp == 2'b00) ? OUT : HALT;
          end
        end
        OUT: begin
          if (out_ready) begin
            cnt_q <= cnt_q + 32'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (npc_valid) begin
            if (npc[1:0] == 2'b00) begin
              pc    <= npc;
              state <= AR;
            end else begin
              state <= HALT;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign bus.arvalid = (state == AR);
  assign bus.rready  = (state == R);
  assign out_valid   = (state == OUT);
  assign fault       = (state == HALT);

  assign bus.araddr  = pc;
  assign out_pc      = pc;
  assign out_inst    = inst;
  assign fetch_cnt   = cnt_q;

endmodule

// File: doc/ysyx_23060111_ifu_axil.md
# ysyx_23060111_ifu_axil

Multi-cycle instruction fetch unit for the ysyx_23060111 core, replacing the combinational fetch path. Holds the PC, issues one read per instruction on a simplified AXI-lite read channel (AR/R), and presents the fetched word to the decode stage through a valid/ready handshake. It then waits for the execute stage to return the next PC before fetching again. The core is single-issue and non-overlapped: exactly one instruction is in flight.

## Interface

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge.
- araddr  out  32  fetch address, equal to the internal pc.
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts the address.
- rdata  in  32  read data.
- rresp  in  2  read response; 2'b00 = OKAY, any other value is an error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_inst  out  32  fetched instruction word.
- out_pc  out  32  address of out_inst.
- npc_valid  in  1  execute stage presents the next PC.
- npc  in  32  next PC (dnpc).
- fault  out  1  sticky: bus error or misaligned npc; fetch halted.
- fetch_cnt  out  32  count of instructions handed to decode.

## Operation

- States: IDLE, AR, R, OUT, WAIT, HALT. All handshake outputs are decoded from state only:
  - arvalid = (AR)
  - rready = (R)
  - out_valid = (OUT)
  - fault = (HALT)
- Reset (rst=0 at a clock edge):
  - state <= IDLE, pc <= RESET_PC, inst <= 0, fetch_cnt <= 0.
  - While in reset, all outputs are 0 except araddr = out_pc = RESET_PC.
- IDLE → AR unconditionally on the first edge with rst=1.
- AR: hold arvalid=1 with araddr stable until arready=1, then go to R. rvalid is ignored in AR.
- R: on rvalid=1 (rready is 1), capture rdata into inst.
  - If rresp==0, go to OUT.
  - Otherwise go to HALT; inst is still captured.
- OUT: out_valid=1; out_inst and out_pc are stable until out_ready=1.
  - On the handshake, fetch_cnt += 1 (wraps 2^32−1 → 0) and go to WAIT.
- WAIT: npc_valid is sampled only in this state.
  - If npc_valid=1 and npc[1:0]==0: pc <= npc, go to AR.
  - If npc_valid=1 and npc[1:0]!=0: pc is unchanged, go to HALT.
  - If npc_valid=0: stay in WAIT.
- HALT: terminal. The only exit is reset. No bus activity occurs.
- npc_valid in any state other than WAIT is ignored. out_ready outside OUT is ignored.
- arready/rvalid stalls of any length are legal and must not lose data.

## Timing

- Best-case loop, with arready=1, rvalid=1 on first assertion, out_ready=1, and npc_valid=1:
  - cycle n: AR
  - cycle n+1: R
  - cycle n+2: OUT
  - cycle n+3: WAIT
  - cycle n+4: AR with the new araddr
  - This gives 4 cycles per instruction.
- The first arvalid rises in the second cycle after rst deasserts (one IDLE cycle).
- out_inst and out_pc are registered; they change only on the R→OUT edge and the WAIT→AR edge respectively.
- fetch_cnt updates on the edge that completes the OUT handshake and is visible the following cycle.
- Reset asserted mid-transaction (any state) aborts it at that edge: the next cycle shows state IDLE and arvalid=rready=out_valid=0. A pending memory response arriving later is ignored because the unit is not in R until a new AR completes.
- No combinational path exists from any input to arvalid, rready, out_valid or fault.

## Test plan

- Reset/first fetch:
  - Stimulus: rst low 3 cycles, then high; arready=1; rvalid=1 with rdata=32'h0010_0093 and rresp=0.
  - Response: araddr=32'h8000_0000; arvalid rises 2 cycles after release; out_valid 2 cycles later with out_inst=32'h0010_0093 and out_pc=32'h8000_0000.
- Backpressure:
  - Stimulus: arready low 5 cycles, rvalid low 3 cycles, out_ready low 4 cycles.
  - Response: araddr, out_inst and out_pc are stable throughout; exactly one capture; fetch_cnt increments by exactly 1.
- Redirect:
  - Stimulus: in WAIT, npc_valid=0 for 3 cycles, then npc=32'h8000_0010.
  - Response: no arvalid while waiting; the next AR shows araddr=32'h8000_0010. An npc_valid pulse during OUT has no effect.
- Faults:
  - Stimulus A: rresp=2'b10 on a fetch. Response: fault=1, out_valid never asserts, no further arvalid.
  - Stimulus B: npc=32'h8000_0002. Response: fault=1 and araddr remains at the old pc.
- Reset mid-operation:
  - Stimulus: rst=0 during R, then a late rvalid.
  - Response: the late rvalid is not captured; the unit restarts fetching at RESET_PC and fetch_cnt=0.
- Counter wrap:
  - Stimulus: force fetch_cnt to 32'hFFFF_FFFF, then complete one OUT handshake.
  - Response: fetch_cnt=0.
